// File: rtl/cfg_tile_pkg.sv
//------------------------------------------------------------------------------
// cfg_tile_pkg : shared feature codes, address field layout and read FSM states
// Revision 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

package cfg_tile_pkg;

  localparam logic [7:0] FEAT_REG  = 8'h00;
  localparam logic [7:0] FEAT_SRAM = 8'h01;

  // config address layout: {index[31:24], feature[23:16], tile_xy[15:0]}
  localparam int IDX_LSB  = 24;
  localparam int FEAT_LSB = 16;
  localparam int TILE_LSB = 0;
  localparam int FIELD_W  = 8;
  localparam int TILE_W   = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SRD1 = 2'd1,
    ST_SRD2 = 2'd2
  } rd_state_t;

endpackage

`default_nettype wire

// File: rtl/cfg_tile_sram.sv
//------------------------------------------------------------------------------
// cfg_tile_sram : DEPTH x 32 single-port SRAM, synchronous read-before-write
// Revision 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

module cfg_tile_sram #(
  parameter  int DEPTH = 256,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          en,
  input  logic          wen,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;

  // array and output register are intentionally not reset
  always_ff @(posedge clk) begin
    if (en) begin
      if (wen) begin
        r_mem[addr] <= wdata;
      end
      r_rdata <= r_mem[addr];
    end
  end

  assign rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/cfg_tile_responder.sv
//------------------------------------------------------------------------------
// cfg_tile_responder : per-tile config register / SRAM responder.
// Readback paths exist only when CFG_TILE_READBACK_EN is defined.
// Revision 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

module cfg_tile_responder
  import cfg_tile_pkg::*;
#(
  parameter  logic [15:0] TILE_XY    = 16'h0000,
  parameter  int          NUM_REGS   = 8,
  parameter  int          SRAM_DEPTH = 256,
  localparam int          AW         = (SRAM_DEPTH > 1) ? $clog2(SRAM_DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic [31:0]           config_config_addr,
  input  logic [31:0]           config_config_data,
  input  logic                  config_read,
  input  logic                  config_write,
  output logic [31:0]           read_config_data,
  output logic [NUM_REGS*32-1:0] cfg_regs,
  input  logic [AW-1:0]         core_sram_addr,
  input  logic                  core_sram_wen,
  input  logic [31:0]           core_sram_wdata,
  output logic [31:0]           core_sram_rdata
);

  localparam int RW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [7:0]    w_idx;
  logic [7:0]    w_feat;
  logic          w_match;
  logic          w_idle;
  logic          w_reg_hit;
  logic          w_sram_hit;
  logic          w_wr;
  logic          w_reg_wr;
  logic          w_sram_wr;
  logic          w_sram_rd;
  logic          w_mem_en;
  logic          w_mem_wen;
  logic [AW-1:0] w_mem_addr;
  logic [31:0]   w_mem_wdata;
  logic [31:0]   w_mem_rdata;
  logic [31:0]   r_regs [NUM_REGS];
  logic          r_core_vld;

  assign w_idx      = config_config_addr[IDX_LSB +: FIELD_W];
  assign w_feat     = config_config_addr[FEAT_LSB +: FIELD_W];
  assign w_match    = (config_config_addr[TILE_LSB +: TILE_W] == TILE_XY);
  assign w_reg_hit  = (int'(w_idx) < NUM_REGS);
  assign w_sram_hit = (int'(w_idx) < SRAM_DEPTH);

  assign w_wr      = config_write & w_match & w_idle;
  assign w_reg_wr  = w_wr & (w_feat == FEAT_REG) & w_reg_hit;
  assign w_sram_wr = w_wr & (w_feat == FEAT_SRAM) & w_sram_hit & stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_reg_wr) begin
      r_regs[RW'(w_idx)] <= config_config_data;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign cfg_regs[g*32 +: 32] = r_regs[g];
  end

  // SRAM belongs to the core while running, to the config bus while stalled
  always_comb begin
    w_mem_en    = w_sram_wr | w_sram_rd;
    w_mem_wen   = w_sram_wr;
    w_mem_addr  = AW'(w_idx);
    w_mem_wdata = config_config_data;
    if (!stall) begin
      w_mem_en    = 1'b1;
      w_mem_wen   = core_sram_wen;
      w_mem_addr  = core_sram_addr;
      w_mem_wdata = core_sram_wdata;
    end
  end

  cfg_tile_sram #(
    .DEPTH (SRAM_DEPTH)
  ) u_sram (
    .clk   (clk),
    .en    (w_mem_en),
    .wen   (w_mem_wen),
    .addr  (w_mem_addr),
    .wdata (w_mem_wdata),
    .rdata (w_mem_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_core_vld <= 1'b0;
    end else begin
      r_core_vld <= ~stall;
    end
  end

  assign core_sram_rdata = r_core_vld ? w_mem_rdata : '0;

`ifdef CFG_TILE_READBACK_EN
  rd_state_t   r_state;
  rd_state_t   w_state_nxt;
  logic [31:0] r_rdata;
  logic [31:0] w_rdata_nxt;
  logic        w_rd;

  assign w_idle    = (r_state == ST_IDLE);
  assign w_rd      = config_read & ~config_write & w_match & w_idle;
  assign w_sram_rd = w_rd & (w_feat == FEAT_SRAM) & w_sram_hit & stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_sram_rd) w_state_nxt = ST_SRD1;
      ST_SRD1: w_state_nxt = stall ? ST_SRD2 : ST_IDLE;
      ST_SRD2: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // a falling stall mid-read aborts it and zeroes the readback
  always_comb begin
    w_rdata_nxt = r_rdata;
    case (r_state)
      ST_IDLE: begin
        if ((config_read | config_write) & ~w_match) begin
          w_rdata_nxt = '0;
        end else if (w_rd) begin
          if (w_feat == FEAT_REG) begin
            w_rdata_nxt = w_reg_hit ? r_regs[RW'(w_idx)] : '0;
          end else if (!w_sram_rd) begin
            w_rdata_nxt = '0;
          end
        end
      end
      ST_SRD1: w_rdata_nxt = stall ? w_mem_rdata : '0;
      ST_SRD2: if (!stall) w_rdata_nxt = '0;
      default: w_rdata_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rdata <= '0;
    end else begin
      r_rdata <= w_rdata_nxt;
    end
  end

  assign read_config_data = r_rdata;
`else
  logic w_unused_read;

  assign w_idle           = 1'b1;
  assign w_sram_rd        = 1'b0;
  assign w_unused_read    = config_read;
  assign read_config_data = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cfg_tile_responder.sv
//------------------------------------------------------------------------------
// tb_cfg_tile_responder : directed self-checking bench for cfg_tile_responder
// Revision 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_cfg_tile_responder;

  localparam logic [15:0] TILE = 16'h0201;
  localparam logic [7:0]  F_REG  = 8'h00;
  localparam logic [7:0]  F_SRAM = 8'h01;
`ifdef CFG_TILE_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         stall = 1'b1;
  logic [31:0]  config_config_addr = '0;
  logic [31:0]  config_config_data = '0;
  logic         config_read = 1'b0;
  logic         config_write = 1'b0;
  logic [7:0]   core_sram_addr = '0;
  logic         core_sram_wen = 1'b0;
  logic [31:0]  core_sram_wdata = '0;
  logic [31:0]  read_config_data;
  logic [255:0] cfg_regs;
  logic [31:0]  core_sram_rdata;

  int           n_run = 0;
  int           n_fail = 0;
  logic [255:0] exp_regs = '0;
  logic [31:0]  exp_rd;
  logic [31:0]  prev_rd;

  cfg_tile_responder #(
    .TILE_XY    (TILE),
    .NUM_REGS   (8),
    .SRAM_DEPTH (256)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .stall              (stall),
    .config_config_addr (config_config_addr),
    .config_config_data (config_config_data),
    .config_read        (config_read),
    .config_write       (config_write),
    .read_config_data   (read_config_data),
    .cfg_regs           (cfg_regs),
    .core_sram_addr     (core_sram_addr),
    .core_sram_wen      (core_sram_wen),
    .core_sram_wdata    (core_sram_wdata),
    .core_sram_rdata    (core_sram_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] pat(input logic [7:0] i);
    return {i, ~i, 8'hC3, i};
  endfunction

  function automatic logic [31:0] rbv(input logic [31:0] v);
    return RB ? v : 32'h0;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [7:0] idx, input logic [7:0] feat, input logic [31:0] data);
    config_config_addr = {idx, feat, TILE};
    config_config_data = data;
    config_write = 1'b1;
    tick;
    config_write = 1'b0;
  endtask

  task automatic cfg_read(input logic [31:0] addr);
    config_config_addr = addr;
    config_read = 1'b1;
    tick;
    config_read = 1'b0;
  endtask

  task automatic core_read(input logic [7:0] addr);
    core_sram_addr = addr;
    core_sram_wen = 1'b0;
    tick;
  endtask

  task automatic test_reset;
    #2 reset = 1'b0;
    #1;
    n_run++; if (read_config_data !== 32'h0) begin n_fail++; $display("FAIL reset_rcd: got %h expected %h", read_config_data, 32'h0); end
    n_run++; if (core_sram_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_core: got %h expected %h", core_sram_rdata, 32'h0); end
    n_run++; if (cfg_regs !== 256'h0) begin n_fail++; $display("FAIL reset_regs: got %h expected 0", cfg_regs); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    tick;
  endtask

  task automatic test_reg;
    cfg_write(8'h03, F_REG, 32'h001C_7E00);
    exp_regs[127:96] = 32'h001C_7E00;
    n_run++; if (cfg_regs[127:96] !== 32'h001C_7E00) begin n_fail++; $display("FAIL reg3_write: got %h expected %h", cfg_regs[127:96], 32'h001C_7E00); end
    n_run++; if (read_config_data !== 32'h0) begin n_fail++; $display("FAIL write_no_rd: got %h expected %h", read_config_data, 32'h0); end
    cfg_read(32'h0300_0201);
    n_run++; if (read_config_data !== rbv(32'h001C_7E00)) begin n_fail++; $display("FAIL reg3_read: got %h expected %h", read_config_data, rbv(32'h001C_7E00)); end
    cfg_write(8'h07, F_REG, 32'hA5A5_0007);
    cfg_write(8'h08, F_REG, 32'hFFFF_FFFF);
    exp_regs[255:224] = 32'hA5A5_0007;
    n_run++; if (cfg_regs !== exp_regs) begin n_fail++; $display("FAIL reg_oob_write: got %h expected %h", cfg_regs, exp_regs); end
    cfg_read(32'h0800_0201);
    n_run++; if (read_config_data !== 32'h0) begin n_fail++; $display("FAIL reg_oob_read: got %h expected %h", read_config_data, 32'h0); end
    cfg_read(32'h0700_0201);
    n_run++; if (read_config_data !== rbv(32'hA5A5_0007)) begin n_fail++; $display("FAIL reg7_read: got %h expected %h", read_config_data, rbv(32'hA5A5_0007)); end
  endtask

  task automatic test_sram_fill;
    logic [7:0] samples [8];
    samples = '{8'd0, 8'd1, 8'd5, 8'd77, 8'd128, 8'd200, 8'd254, 8'd255};
    stall = 1'b1;
    for (int i = 0; i < 256; i++) cfg_write(8'(i), F_SRAM, pat(8'(i)));
    prev_rd = rbv(32'hA5A5_0007);
    for (int k = 0; k < 8; k++) begin
      cfg_read({samples[k], F_SRAM, TILE});
      n_run++; if (read_config_data !== prev_rd) begin n_fail++; $display("FAIL sram_rd_hold[%0d]: got %h expected %h", samples[k], read_config_data, prev_rd); end
      tick;
      exp_rd = rbv(pat(samples[k]));
      n_run++; if (read_config_data !== exp_rd) begin n_fail++; $display("FAIL sram_rd_pat[%0d]: got %h expected %h", samples[k], read_config_data, exp_rd); end
      prev_rd = exp_rd;
      tick;
    end
    stall = 1'b0;
    for (int k = 0; k < 8; k++) begin
      core_read(samples[k]);
      n_run++; if (core_sram_rdata !== pat(samples[k])) begin n_fail++; $display("FAIL core_rd_pat[%0d]: got %h expected %h", samples[k], core_sram_rdata, pat(samples[k])); end
    end
    stall = 1'b1;
    tick;
    for (int i = 0; i < 256; i++) cfg_write(8'(i), F_SRAM, 32'h0000_0099);
    for (int i = 0; i < 256; i++) begin
      cfg_read({8'(i), F_SRAM, TILE});
      n_run++; if (read_config_data !== prev_rd) begin n_fail++; $display("FAIL sram99_hold[%0d]: got %h expected %h", i, read_config_data, prev_rd); end
      tick;
      n_run++; if (read_config_data !== rbv(32'h99)) begin n_fail++; $display("FAIL sram99_read[%0d]: got %h expected %h", i, read_config_data, rbv(32'h99)); end
      prev_rd = rbv(32'h99);
      tick;
    end
  endtask

  task automatic test_stall_write;
    stall = 1'b0;
    cfg_write(8'd5, F_SRAM, 32'h0000_1234);
    core_read(8'd5);
    n_run++; if (core_sram_rdata !== 32'h99) begin n_fail++; $display("FAIL run_cfg_wr_drop: got %h expected %h", core_sram_rdata, 32'h99); end
    core_sram_addr = 8'd9; core_sram_wdata = 32'h5555_AAAA; core_sram_wen = 1'b1;
    tick;
    core_sram_wen = 1'b0;
    core_read(8'd9);
    n_run++; if (core_sram_rdata !== 32'h5555_AAAA) begin n_fail++; $display("FAIL core_wr_rd: got %h expected %h", core_sram_rdata, 32'h5555_AAAA); end
    stall = 1'b1;
    core_sram_addr = 8'd10; core_sram_wdata = 32'h0000_DEAD; core_sram_wen = 1'b1;
    tick;
    core_sram_wen = 1'b0;
    n_run++; if (core_sram_rdata !== 32'h0) begin n_fail++; $display("FAIL core_stalled: got %h expected %h", core_sram_rdata, 32'h0); end
    stall = 1'b0;
    core_read(8'd10);
    n_run++; if (core_sram_rdata !== 32'h99) begin n_fail++; $display("FAIL core_stalled_wr: got %h expected %h", core_sram_rdata, 32'h99); end
    cfg_read({8'd5, F_SRAM, TILE});
    n_run++; if (read_config_data !== 32'h0) begin n_fail++; $display("FAIL run_sram_rd: got %h expected %h", read_config_data, 32'h0); end
    cfg_read(32'h0300_0201);
    n_run++; if (read_config_data !== rbv(32'h001C_7E00)) begin n_fail++; $display("FAIL run_then_reg: got %h expected %h", read_config_data, rbv(32'h001C_7E00)); end
  endtask

  task automatic test_other_tile;
    cfg_read(32'h0000_0301);
    n_run++; if (read_config_data !== 32'h0) begin n_fail++; $display("FAIL other_rd: got %h expected %h", read_config_data, 32'h0); end
    config_config_addr = {8'h00, F_REG, 16'h0301};
    config_config_data = 32'h0000_0BAD;
    config_write = 1'b1;
    tick;
    config_write = 1'b0;
    n_run++; if (cfg_regs !== exp_regs) begin n_fail++; $display("FAIL other_wr: got %h expected %h", cfg_regs, exp_regs); end
    cfg_read(32'h0300_0201);
    config_config_addr = {8'h00, F_REG, TILE};
    config_config_data = 32'h0000_CAFE;
    config_read = 1'b1;
    config_write = 1'b1;
    tick;
    config_read = 1'b0;
    config_write = 1'b0;
    exp_regs[31:0] = 32'h0000_CAFE;
    n_run++; if (cfg_regs !== exp_regs) begin n_fail++; $display("FAIL rdwr_write: got %h expected %h", cfg_regs, exp_regs); end
    n_run++; if (read_config_data !== rbv(32'h001C_7E00)) begin n_fail++; $display("FAIL rdwr_hold: got %h expected %h", read_config_data, rbv(32'h001C_7E00)); end
  endtask

  task automatic test_unmapped;
    cfg_write(8'h00, 8'h02, 32'h0000_1111);
    n_run++; if (cfg_regs !== exp_regs) begin n_fail++; $display("FAIL unmapped_wr: got %h expected %h", cfg_regs, exp_regs); end
    n_run++; if (read_config_data !== rbv(32'h001C_7E00)) begin n_fail++; $display("FAIL unmapped_wr_hold: got %h expected %h", read_config_data, rbv(32'h001C_7E00)); end
    cfg_read({8'h00, 8'hFF, TILE});
    n_run++; if (read_config_data !== 32'h0) begin n_fail++; $display("FAIL unmapped_rd: got %h expected %h", read_config_data, 32'h0); end
  endtask

  task automatic test_srd_ignore;
    stall = 1'b1;
    cfg_read({8'd9, F_SRAM, TILE});
    cfg_write(8'h01, F_REG, 32'hDEAD_0001);
    n_run++; if (read_config_data !== rbv(32'h5555_AAAA)) begin n_fail++; $display("FAIL srd_data: got %h expected %h", read_config_data, rbv(32'h5555_AAAA)); end
    exp_regs[63:32] = RB ? 32'h0 : 32'hDEAD_0001;
    n_run++; if (cfg_regs !== exp_regs) begin n_fail++; $display("FAIL srd_ignore_wr: got %h expected %h", cfg_regs, exp_regs); end
    tick;
  endtask

  task automatic test_abort;
    stall = 1'b1;
    cfg_read(32'h0300_0201);
    cfg_read({8'd5, F_SRAM, TILE});
    stall = 1'b0;
    tick;
    n_run++; if (read_config_data !== 32'h0) begin n_fail++; $display("FAIL abort_rcd: got %h expected %h", read_config_data, 32'h0); end
    cfg_read(32'h0300_0201);
    n_run++; if (read_config_data !== rbv(32'h001C_7E00)) begin n_fail++; $display("FAIL abort_idle: got %h expected %h", read_config_data, rbv(32'h001C_7E00)); end
    stall = 1'b1;
    cfg_read({8'd5, F_SRAM, TILE});
    tick;
    n_run++; if (read_config_data !== rbv(32'h99)) begin n_fail++; $display("FAIL srd2_data: got %h expected %h", read_config_data, rbv(32'h99)); end
    #2 reset = 1'b0;
    #1;
    n_run++; if (read_config_data !== 32'h0) begin n_fail++; $display("FAIL midrd_reset_rcd: got %h expected %h", read_config_data, 32'h0); end
    n_run++; if (cfg_regs !== 256'h0) begin n_fail++; $display("FAIL midrd_reset_regs: got %h expected 0", cfg_regs); end
    n_run++; if (core_sram_rdata !== 32'h0) begin n_fail++; $display("FAIL midrd_reset_core: got %h expected %h", core_sram_rdata, 32'h0); end
    @(negedge clk);
    reset = 1'b1;
    stall = 1'b0;
    tick;
    n_run++; if (read_config_data !== 32'h0) begin n_fail++; $display("FAIL post_reset_rcd: got %h expected %h", read_config_data, 32'h0); end
    core_read(8'd5);
    n_run++; if (core_sram_rdata !== 32'h99) begin n_fail++; $display("FAIL sram_retained: got %h expected %h", core_sram_rdata, 32'h99); end
  endtask

  initial begin
    test_reset;
    test_reg;
    test_sram_fill;
    test_stall_write;
    test_other_tile;
    test_unmapped;
    test_srd_ignore;
    test_abort;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
